// File: rtl/barrel_spawn_ctrl.sv
// Barrel slot scheduler: frame-paced spawning, slot freeing, Donkey damage/lives and game FSM.
// Optional macro BARREL_SPEEDUP_EN shortens the spawn period every 4 spawns (floored at a quarter).
module barrel_spawn_ctrl #(
  parameter int BARRELS       = 5,
  parameter int SPAWN_PERIOD  = 90,
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               frame_tick,
  input  logic [BARRELS-1:0] hit,
  input  logic [BARRELS-1:0] off_screen,
  output logic [BARRELS-1:0] barrel,
  output logic [BARRELS-1:0] spawn,
  output logic               damage,
  output logic [2:0]         lives,
  output logic               running,
  output logic               game_over
);

  localparam int TW = $clog2(SPAWN_PERIOD + 1);
  localparam int IW = $clog2(INVULN_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t             state_q, state_d;
  logic [BARRELS-1:0] barrel_q, barrel_d, spawn_q, spawn_d;
  logic               damage_q, damage_d, running_q, running_d, over_q, over_d;
  logic [2:0]         lives_q, lives_d;
  logic [TW-1:0]      timer_q, timer_d, period_last;
  logic               pending_q, pending_d;
  logic [IW-1:0]      invuln_q, invuln_d;

  logic [BARRELS-1:0] free_slots, alloc_oh, release_mask;
  logic               alloc_vld, expire, hit_any, start_run;

  // Lowest set bit of the free mask via two's complement isolation.
  assign free_slots   = ~barrel_q;
  assign alloc_oh     = free_slots & (~free_slots + BARRELS'(1));
  assign alloc_vld    = pending_q & (|free_slots);
  assign release_mask = (hit | off_screen) & barrel_q;
  assign hit_any      = |(hit & barrel_q);
  assign expire       = frame_tick & (timer_q >= period_last);
  assign start_run    = start & (state_q != RUN);

`ifdef BARREL_SPEEDUP_EN
  localparam int STEP  = SPAWN_PERIOD / 8;
  localparam int FLOOR = SPAWN_PERIOD / 4;

  logic [TW-1:0] period_q, period_d;
  logic [1:0]    nspawn_q, nspawn_d;

  assign period_last = period_q - TW'(1);

  always_comb begin
    period_d = period_q;
    nspawn_d = nspawn_q;
    if (start_run) begin
      period_d = TW'(SPAWN_PERIOD);
      nspawn_d = 2'd0;
    end else if (|spawn_d) begin
      nspawn_d = nspawn_q + 2'd1;
      if (nspawn_q == 2'd3)
        period_d = (period_q >= TW'(FLOOR + STEP)) ? period_q - TW'(STEP) : TW'(FLOOR);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q <= TW'(SPAWN_PERIOD);
      nspawn_q <= 2'd0;
    end else begin
      period_q <= period_d;
      nspawn_q <= nspawn_d;
    end
  end
`else
  assign period_last = TW'(SPAWN_PERIOD - 1);
`endif

  always_comb begin
    state_d   = state_q;
    barrel_d  = barrel_q;
    spawn_d   = '0;
    damage_d  = 1'b0;
    lives_d   = lives_q;
    timer_d   = timer_q;
    pending_d = pending_q;
    invuln_d  = invuln_q;
    unique case (state_q)
      IDLE, OVER: begin
        barrel_d  = '0;
        timer_d   = '0;
        pending_d = 1'b0;
        if (start) begin
          state_d   = RUN;
          lives_d   = 3'(LIVES);
          pending_d = 1'b1;
          invuln_d  = '0;
        end
      end
      RUN: begin
        if (lives_q == 3'd0) begin
          // Last life went on the previous cycle; clear the playfield as we leave.
          state_d   = OVER;
          barrel_d  = '0;
          timer_d   = '0;
          pending_d = 1'b0;
          invuln_d  = '0;
        end else begin
          if (frame_tick)
            timer_d = expire ? '0 : timer_q + TW'(1);
          barrel_d  = (barrel_q & ~release_mask) | (alloc_vld ? alloc_oh : '0);
          spawn_d   = alloc_vld ? alloc_oh : '0;
          pending_d = (pending_q & ~alloc_vld) | expire;
          if (hit_any && invuln_q == '0) begin
            damage_d = 1'b1;
            lives_d  = lives_q - 3'd1;
            invuln_d = IW'(INVULN_FRAMES);
          end else if (frame_tick && invuln_q != '0) begin
            invuln_d = invuln_q - IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
    over_d    = (state_d == OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      barrel_q  <= '0;
      spawn_q   <= '0;
      damage_q  <= 1'b0;
      lives_q   <= 3'd0;
      timer_q   <= '0;
      pending_q <= 1'b0;
      invuln_q  <= '0;
      running_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      barrel_q  <= barrel_d;
      spawn_q   <= spawn_d;
      damage_q  <= damage_d;
      lives_q   <= lives_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      invuln_q  <= invuln_d;
      running_q <= running_d;
      over_q    <= over_d;
    end
  end

  assign barrel    = barrel_q;
  assign spawn     = spawn_q;
  assign damage    = damage_q;
  assign lives     = lives_q;
  assign running   = running_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_barrel_spawn_ctrl.sv
// Directed bench for barrel_spawn_ctrl with BARRELS=2, SPAWN_PERIOD=4, LIVES=3, INVULN_FRAMES=2.
module tb_barrel_spawn_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       frame_tick = 1'b0;
  logic [1:0] hit = 2'b00;
  logic [1:0] off_screen = 2'b00;
  logic [1:0] barrel, spawn;
  logic       damage, running, game_over;
  logic [2:0] lives;

  int vectors = 0;
  int miscompares = 0;
  logic any_spawn;

  barrel_spawn_ctrl #(
    .BARRELS(2), .SPAWN_PERIOD(4), .LIVES(3), .INVULN_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick),
    .hit(hit), .off_screen(off_screen), .barrel(barrel), .spawn(spawn),
    .damage(damage), .lives(lives), .running(running), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    cyc(); cyc();
    chk("rst_barrel", 16'(barrel), 16'h0);
    chk("rst_spawn", 16'(spawn), 16'h0);
    chk("rst_lives", 16'(lives), 16'h0);
    chk("rst_running", 16'(running), 16'h0);
    chk("rst_over", 16'(game_over), 16'h0);
    chk("rst_damage", 16'(damage), 16'h0);
    rst = 1'b0;
    cyc();
    chk("idle_running", 16'(running), 16'h0);

    // 1: start, first spawn, timer-driven second spawn
    start = 1'b1; cyc(); start = 1'b0;
    chk("t1_running", 16'(running), 16'h1);
    chk("t1_lives", 16'(lives), 16'h3);
    chk("t1_barrel0", 16'(barrel), 16'h0);
    cyc();
    chk("t1_spawn01", 16'(spawn), 16'h1);
    chk("t1_barrel01", 16'(barrel), 16'h1);
    ticks(4);
    chk("t1_no_early_spawn", 16'(spawn), 16'h0);
    cyc();
    chk("t1_spawn10", 16'(spawn), 16'h2);
    chk("t1_barrel11", 16'(barrel), 16'h3);
    cyc();
    chk("t1_spawn_pulse", 16'(spawn), 16'h0);

    // 2: pool full, pending held until a slot frees
    ticks(4);
    cyc(); cyc();
    chk("t2_full_spawn", 16'(spawn), 16'h0);
    chk("t2_full_barrel", 16'(barrel), 16'h3);
    off_screen = 2'b01; cyc(); off_screen = 2'b00;
    chk("t2_freed_barrel", 16'(barrel), 16'h2);
    chk("t2_freed_spawn", 16'(spawn), 16'h0);
    cyc();
    chk("t2_realloc_spawn", 16'(spawn), 16'h1);
    chk("t2_realloc_barrel", 16'(barrel), 16'h3);

    // Free slot 1, then a hit on the inactive slot must be ignored
    off_screen = 2'b10; cyc(); off_screen = 2'b00;
    chk("inact_setup_barrel", 16'(barrel), 16'h1);
    hit = 2'b10; cyc(); hit = 2'b00;
    chk("inact_damage", 16'(damage), 16'h0);
    chk("inact_lives", 16'(lives), 16'h3);
    chk("inact_barrel", 16'(barrel), 16'h1);

    // 3: hit on slot 0 in the same cycle slot 1 is allocated
    ticks(4);
    chk("t3_pre_barrel", 16'(barrel), 16'h1);
    hit = 2'b01; cyc(); hit = 2'b00;
    chk("t3_barrel", 16'(barrel), 16'h2);
    chk("t3_spawn", 16'(spawn), 16'h2);
    chk("t3_damage", 16'(damage), 16'h1);
    chk("t3_lives", 16'(lives), 16'h2);
    cyc();
    chk("t3_damage_pulse", 16'(damage), 16'h0);

    // 4: hit during invulnerability frees the slot but costs no life
    ticks(1);
    hit = 2'b10; cyc(); hit = 2'b00;
    chk("t4_inv_lives", 16'(lives), 16'h2);
    chk("t4_inv_damage", 16'(damage), 16'h0);
    chk("t4_inv_barrel", 16'(barrel), 16'h0);
    ticks(3);
    cyc();
    chk("t4_respawn", 16'(barrel), 16'h1);
    hit = 2'b01; cyc(); hit = 2'b00;
    chk("t4_lives", 16'(lives), 16'h1);
    chk("t4_damage", 16'(damage), 16'h1);
    chk("t4_barrel", 16'(barrel), 16'h0);

    // 5: last life, game over, no spawns, restart
    ticks(4);
    cyc();
    chk("t5_respawn", 16'(barrel), 16'h1);
    hit = 2'b01; cyc(); hit = 2'b00;
    chk("t5_lives0", 16'(lives), 16'h0);
    chk("t5_still_running", 16'(running), 16'h1);
    cyc();
    chk("t5_over", 16'(game_over), 16'h1);
    chk("t5_running", 16'(running), 16'h0);
    chk("t5_barrel", 16'(barrel), 16'h0);
    any_spawn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ticks(1);
      any_spawn = any_spawn | (|spawn) | (|barrel);
    end
    chk("t5_no_spawn", 16'(any_spawn), 16'h0);
    chk("t5_lives_hold", 16'(lives), 16'h0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("t5_restart_running", 16'(running), 16'h1);
    chk("t5_restart_lives", 16'(lives), 16'h3);
    chk("t5_restart_over", 16'(game_over), 16'h0);
    cyc();
    chk("t5_restart_spawn", 16'(spawn), 16'h1);

    // 6: asynchronous reset mid-game
    ticks(4);
    cyc();
    chk("t6_barrel11", 16'(barrel), 16'h3);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_barrel", 16'(barrel), 16'h0);
    chk("t6_async_running", 16'(running), 16'h0);
    chk("t6_async_lives", 16'(lives), 16'h0);
    chk("t6_async_spawn", 16'(spawn), 16'h0);
    #1 rst = 1'b0;
    cyc(); cyc();
    chk("t6_needs_start", 16'(running), 16'h0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("t6_resume", 16'(running), 16'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
